switch_debouncer: RTL and testbench
===================================

Name: switch_debouncer

Overview:
- Input-conditioning stage placed directly upstream of the up/down load counter and 7-segment stage.
- Synchronises the 8 raw switch inputs SWI to clk_2 and debounces each bit independently.
- Outputs the stable switch vector plus one-cycle rise and fall pulses per bit. The counter stage consumes reset/select/load value from sw_stable instead of raw SWI.
- Also provides a ready flag so downstream logic ignores the switches until the filter has settled after reset.

Parameters:
NBITS_SW, 8, number of switch bits conditioned
DEBOUNCE_CYCLES, 4, consecutive clk_2 cycles a synchronised bit must disagree with its stable value before it is accepted; legal range 1..255
SYNC_STAGES, 2, flip-flop stages in the synchroniser; legal range 2..3

Ports:
clk_2  input  1  the single clock; all state updates on its rising edge
reset_n  input  1  asynchronous, active-low reset; asserting it immediately forces all state to reset values; release is sampled on clk_2
SWI  input  NBITS_SW  raw switch levels, asynchronous to clk_2
sw_stable  output  NBITS_SW  debounced switch levels
sw_rise  output  NBITS_SW  one-cycle pulse per bit when sw_stable[i] goes 0->1
sw_fall  output  NBITS_SW  one-cycle pulse per bit when sw_stable[i] goes 1->0
sw_change  output  1  one-cycle pulse, OR of all sw_rise and sw_fall bits, registered in the same cycle
ready  output  1  high once SYNC_STAGES+DEBOUNCE_CYCLES cycles have elapsed since reset release; stays high until next reset

Behaviour:
- Reset (reset_n=0, asynchronous):
  - All synchroniser flops, sw_stable, sw_rise, sw_fall, sw_change and ready go to 0.
  - All per-bit counters go to 0.
  - The settle counter goes to 0.
  - Reset mid-count discards all partial counts.
- Synchroniser: per bit, a chain of SYNC_STAGES flops. sync_out[i] is the last stage. There is no logic between stages.
- Per-bit counter: cnt[i], width clog2(DEBOUNCE_CYCLES+1). On every rising edge of clk_2:
  - If sync_out[i]==sw_stable[i]: cnt[i]<=0.
  - Else if cnt[i]==DEBOUNCE_CYCLES-1:
    - sw_stable[i]<=sync_out[i] and cnt[i]<=0.
    - sw_rise[i]<=sync_out[i]; sw_fall[i]<=~sync_out[i].
  - Else: cnt[i]<=cnt[i]+1.
  - sw_rise[i] and sw_fall[i] are 0 in every cycle without an accept.
- Latency (SYNC_STAGES=2): SWI[i] changes before edge 0 and holds. sw_stable[i] and the pulse update at edge DEBOUNCE_CYCLES+1 (edge 5 with the default). In general the update lands at edge SYNC_STAGES+DEBOUNCE_CYCLES-1.
- Glitch rejection: any return of sync_out[i] to sw_stable[i] before the count completes clears cnt[i]. A pulse shorter than DEBOUNCE_CYCLES synchronised cycles never reaches sw_stable.
- Bits are fully independent. Simultaneous accepts on several bits in one cycle assert all corresponding rise/fall bits in that cycle. sw_change is a single pulse for that cycle.
- Pulse rules:
  - sw_rise[i] and sw_fall[i] are never both 1.
  - A pulse lasts exactly one cycle.
  - A bit accepted on consecutive windows produces separate pulses at least DEBOUNCE_CYCLES cycles apart.
- Switch already high at reset release: sw_stable starts at 0. The bit is accepted as a rise at the normal latency, and the sw_rise pulse fires. Downstream gates its use with ready.
- ready:
  - A settle counter saturates at SYNC_STAGES+DEBOUNCE_CYCLES.
  - ready<=1 on the edge the counter reaches that value.
  - ready never falls except on reset.
- Counter width rule: cnt[i] never exceeds DEBOUNCE_CYCLES-1, so it has no wrap-around. DEBOUNCE_CYCLES=1 accepts on the first disagreeing synchronised cycle.
- All outputs are registered; there are no combinational paths from SWI to any output.

Test Plan:
1. Reset, then SWI=8'h00 held 10 cycles -> sw_stable=00, no pulses, ready=1 from edge 6 onward (default parameters).
2. SWI 00->8'h81 before edge 0, held -> sw_stable=81 at edge 5. At edge 5, sw_rise=81, sw_change=1; both clear at edge 6.
3. SWI[3] high for 2 cycles then low -> sw_stable[3] stays 0; no sw_rise or sw_fall on any bit.
4. From sw_stable=FF, SWI->8'h0F -> at edge 5 sw_stable=0F, sw_fall=F0, sw_rise=00, and sw_change pulses exactly once.
5. SWI[4] toggles 0->1, then after 3 cycles back to 0, then to 1 and held -> the count restarts. sw_stable[4] rises 5 edges after the final toggle, with a single sw_rise pulse.
6. Mid-count (SWI=8'h02 for 3 cycles), assert reset_n=0 asynchronously -> all outputs 0 immediately. After release with SWI still 02, sw_stable=02 at the 5th edge after release, and ready=1 at edge 6.

Source files
------------

// File: rtl/switch_debouncer.sv
// Purpose: synchronise and debounce the raw switch bus; emit the stable levels, per-bit edge pulses and a settled flag.
// Latency: a held input change reaches sw_stable at edge SYNC_STAGES+DEBOUNCE_CYCLES-1; all outputs are registered.
// Backpressure: none; free-running conditioner that samples every clk_2 cycle and never stalls.
module switch_debouncer #(
  parameter int NBITS_SW        = 8,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                clk_2,
  input  logic                reset_n,
  input  logic [NBITS_SW-1:0] SWI,
  output logic [NBITS_SW-1:0] sw_stable,
  output logic [NBITS_SW-1:0] sw_rise,
  output logic [NBITS_SW-1:0] sw_fall,
  output logic                sw_change,
  output logic                ready
);

  localparam int CW     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SETTLE = SYNC_STAGES + DEBOUNCE_CYCLES;
  localparam int SCW    = $clog2(SETTLE + 1);

  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SCW-1:0] SETTLE_V = SCW'(SETTLE);

  // Synchroniser chain; index 0 is the first stage, the top index feeds the filter.
  logic [SYNC_STAGES-1:0][NBITS_SW-1:0] sync_q;
  logic [NBITS_SW-1:0]                  sync_out;

  // Per-bit disagreement counters and their next values.
  logic [NBITS_SW-1:0][CW-1:0] cnt;
  logic [NBITS_SW-1:0][CW-1:0] cnt_nxt;
  logic [NBITS_SW-1:0]         stable_nxt;
  logic [NBITS_SW-1:0]         rise_nxt;
  logic [NBITS_SW-1:0]         fall_nxt;

  // Settle tracking: rel_q marks that the reset release has been sampled.
  logic           rel_q;
  logic [SCW-1:0] settle_cnt;
  logic [SCW-1:0] settle_nxt;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Shift raw switch levels through the synchroniser flops with no logic in between.
  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], SWI};
    end
  end

  // Per-bit filter: count consecutive disagreeing cycles, accept on the last one.
  always_comb begin
    cnt_nxt    = '0;
    stable_nxt = sw_stable;
    rise_nxt   = '0;
    fall_nxt   = '0;
    for (int i = 0; i < NBITS_SW; i++) begin
      if (sync_out[i] != sw_stable[i]) begin
        if (cnt[i] == CNT_LAST) begin
          stable_nxt[i] = sync_out[i];
          rise_nxt[i]   = sync_out[i];
          fall_nxt[i]   = ~sync_out[i];
        end else begin
          cnt_nxt[i] = cnt[i] + 1'b1;
        end
      end
    end
  end

  // Register filter state and the edge pulses; sw_change covers every bit in the same cycle.
  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      cnt       <= '0;
      sw_stable <= '0;
      sw_rise   <= '0;
      sw_fall   <= '0;
      sw_change <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      sw_stable <= stable_nxt;
      sw_rise   <= rise_nxt;
      sw_fall   <= fall_nxt;
      sw_change <= |(rise_nxt | fall_nxt);
    end
  end

  // Settle counter advances only after the release has been sampled and saturates at the settle length.
  always_comb begin
    settle_nxt = settle_cnt;
    if (rel_q && (settle_cnt != SETTLE_V)) begin
      settle_nxt = settle_cnt + 1'b1;
    end
  end

  // ready rises on the edge the settle counter reaches its limit and holds until the next reset.
  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      rel_q      <= 1'b0;
      settle_cnt <= '0;
      ready      <= 1'b0;
    end else begin
      rel_q      <= 1'b1;
      settle_cnt <= settle_nxt;
      if (settle_nxt == SETTLE_V) begin
        ready <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_switch_debouncer.sv
// Purpose: self-checking bench for switch_debouncer (vector table, corner sequences, random vs. window model).
// Latency: expectations are per clk_2 edge; outputs sampled on the falling edge.
// Backpressure: not applicable; stimulus is applied every cycle.
module tb_switch_debouncer;

  localparam int NB   = 8;
  localparam int DEB  = 4;
  localparam int SYNC = 2;
  localparam int LOGN = 4096;

  logic          clk_2 = 1'b0;
  logic          reset_n;
  logic [NB-1:0] SWI;
  logic [NB-1:0] sw_stable;
  logic [NB-1:0] sw_rise;
  logic [NB-1:0] sw_fall;
  logic          sw_change;
  logic          ready;

  int n_cmp = 0;
  int n_bad = 0;

  switch_debouncer #(
    .NBITS_SW(NB), .DEBOUNCE_CYCLES(DEB), .SYNC_STAGES(SYNC)
  ) dut (
    .clk_2(clk_2), .reset_n(reset_n), .SWI(SWI),
    .sw_stable(sw_stable), .sw_rise(sw_rise), .sw_fall(sw_fall),
    .sw_change(sw_change), .ready(ready)
  );

  always #5 clk_2 = ~clk_2;

  // Reference model: a level is accepted when the last DEB synchronised samples all differ
  // from the current stable value. The synchronised sample seen at edge j is the SWI value
  // captured SYNC edges earlier (zero before that, as the flops start cleared).
  logic [NB-1:0] swi_log [LOGN];
  int            m_edge;
  logic [NB-1:0] m_stable, m_rise, m_fall;
  logic          m_change;
  logic          m_ready;

  function automatic logic [NB-1:0] seen_at(int j);
    if (j < SYNC) return '0;
    return swi_log[j - SYNC];
  endfunction

  function automatic logic [NB-1:0] accept_mask(int k);
    logic [NB-1:0] m;
    logic [NB-1:0] s;
    m = '1;
    for (int j = k - DEB + 1; j <= k; j++) begin
      s = seen_at(j);
      m = m & (s ^ m_stable);
    end
    return m;
  endfunction

  always @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      m_edge   <= 0;
      m_stable <= '0;
      m_rise   <= '0;
      m_fall   <= '0;
      m_change <= 1'b0;
    end else begin
      if (m_edge < LOGN) swi_log[m_edge] <= SWI;
      m_stable <= m_stable ^ accept_mask(m_edge);
      m_rise   <= accept_mask(m_edge) & ~m_stable;
      m_fall   <= accept_mask(m_edge) & m_stable;
      m_change <= |accept_mask(m_edge);
      m_edge   <= m_edge + 1;
    end
  end

  // m_edge counts edges since release; edge index SYNC+DEB is the first with ready high.
  assign m_ready = (m_edge > SYNC + DEB);

  typedef struct {
    logic [NB-1:0] swi;
    logic [NB-1:0] st;
    logic [NB-1:0] ri;
    logic [NB-1:0] fa;
    logic          ch;
    logic          rdy;
  } vec_t;

  vec_t tv [18];

  task automatic chk(input string nm, input logic [NB-1:0] act, input logic [NB-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic [NB-1:0] st, input logic [NB-1:0] ri,
                         input logic [NB-1:0] fa, input logic ch, input logic rdy);
    chk({nm, ".stable"}, sw_stable, st);
    chk({nm, ".rise"},   sw_rise,   ri);
    chk({nm, ".fall"},   sw_fall,   fa);
    chk({nm, ".change"}, {7'd0, sw_change}, {7'd0, ch});
    chk({nm, ".ready"},  {7'd0, ready},     {7'd0, rdy});
  endtask

  // Apply v ahead of the next rising edge, then return on the following falling edge.
  task automatic step(input logic [NB-1:0] v);
    SWI = v;
    @(posedge clk_2);
    @(negedge clk_2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nchg;
    int nrise;
    logic [NB-1:0] v;

    // Edges 0..9 idle (ready from edge 6), then 0x81 applied before edge 10, accepted at edge 15.
    for (int k = 0; k < 18; k++) tv[k] = '{swi: 8'h00, st: 8'h00, ri: 8'h00, fa: 8'h00, ch: 1'b0, rdy: 1'b1};
    for (int k = 0; k < 6; k++)  tv[k].rdy = 1'b0;
    for (int k = 10; k < 18; k++) tv[k].swi = 8'h81;
    tv[15] = '{swi: 8'h81, st: 8'h81, ri: 8'h81, fa: 8'h00, ch: 1'b1, rdy: 1'b1};
    tv[16] = '{swi: 8'h81, st: 8'h81, ri: 8'h00, fa: 8'h00, ch: 1'b0, rdy: 1'b1};
    tv[17] = '{swi: 8'h81, st: 8'h81, ri: 8'h00, fa: 8'h00, ch: 1'b0, rdy: 1'b1};

    reset_n = 1'b0;
    SWI     = 8'h5A;
    repeat (3) @(negedge clk_2);
    chk_all("reset", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    SWI     = 8'h00;
    reset_n = 1'b1;

    // Test 1 and 2 from the vector table.
    for (int k = 0; k < 18; k++) begin
      step(tv[k].swi);
      chk_all($sformatf("tbl[%0d]", k), tv[k].st, tv[k].ri, tv[k].fa, tv[k].ch, tv[k].rdy);
    end

    // Test 3: two-cycle glitch on bit 3 is rejected.
    for (int s = 0; s < 10; s++) begin
      step((s < 2) ? 8'h89 : 8'h81);
      chk($sformatf("glitch[%0d].stable", s), sw_stable, 8'h81);
      chk($sformatf("glitch[%0d].pulses", s), sw_rise | sw_fall, 8'h00);
    end

    // Test 4: reach FF, then drop the upper nibble.
    for (int s = 0; s < 8; s++) step(8'hFF);
    chk("to_ff.stable", sw_stable, 8'hFF);
    nchg = 0;
    for (int s = 0; s < 10; s++) begin
      step(8'h0F);
      if (sw_change) nchg++;
      if (s == 5) chk_all("fall_edge5", 8'h0F, 8'h00, 8'hF0, 1'b1, 1'b1);
      else        chk_all($sformatf("fall[%0d]", s), (s < 5) ? 8'hFF : 8'h0F, 8'h00, 8'h00, 1'b0, 1'b1);
    end
    chk("fall.change_count", 8'(nchg), 8'd1);

    // Test 5: bit 4 high 3 cycles, low 1, then high; final toggle before edge 4, accept at edge 9.
    nrise = 0;
    for (int s = 0; s < 14; s++) begin
      step((s == 3) ? 8'h0F : 8'h1F);
      if (sw_rise[4]) nrise++;
      chk($sformatf("restart[%0d].stable", s), sw_stable, (s >= 9) ? 8'h1F : 8'h0F);
      chk($sformatf("restart[%0d].rise", s), sw_rise, (s == 9) ? 8'h10 : 8'h00);
    end
    chk("restart.rise_count", 8'(nrise), 8'd1);

    // Test 6: asynchronous reset mid-count, then recovery with SWI held at 0x02.
    for (int s = 0; s < 3; s++) step(8'h02);
    #2 reset_n = 1'b0;
    #1 chk_all("async_rst", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    @(negedge clk_2);
    reset_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step(8'h02);
      chk_all($sformatf("post_rst[%0d]", k), (k >= 5) ? 8'h02 : 8'h00, (k == 5) ? 8'h02 : 8'h00,
              8'h00, (k == 5), (k >= 6));
    end

    // Random phase against the window model, with one asynchronous reset pulse midway.
    v = 8'h02;
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < NB; b++) if ($urandom_range(5) == 0) v[b] = ~v[b];
      step(v);
      chk_all($sformatf("rnd[%0d]", c), m_stable, m_rise, m_fall, m_change, m_ready);
      if (c == 300) begin
        #3 reset_n = 1'b0;
        @(negedge clk_2);
        chk_all("rnd_rst", m_stable, m_rise, m_fall, m_change, m_ready);
        reset_n = 1'b1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
